// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with flush-to-bubble and optional skid entry.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_reg #(
    parameter int              WIDTH  = 112,
    parameter int              SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
`ifdef PIPE_STAGE_STALL_CNT_EN
    output logic [15:0]      stall_cnt,
`endif
    output logic [1:0]       occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL1 = 2'd1;
    localparam logic [1:0] FULL2 = 2'd2;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] main_q, main_nx, skid_q, skid_nx;
    logic             ready_q;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // in_ready is precomputed from the next state so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            main_q  <= main_nx;
            skid_q  <= skid_nx;
            ready_q <= state_nx != FULL2;
        end
    end

    always_comb begin
        state_nx = state;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = BUBBLE;
        end else if (SKID != 0) begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx = FULL1;
                    main_nx  = in_data;
                end
                FULL1: if (in_fire && out_fire) begin
                    main_nx = in_data;
                end else if (in_fire) begin
                    state_nx = FULL2;
                    skid_nx  = in_data;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
                FULL2: if (out_fire) begin
                    state_nx = FULL1;
                    main_nx  = skid_q;
                end
                default: state_nx = EMPTY;
            endcase
        end else if (in_fire) begin
            state_nx = FULL1;
            main_nx  = in_data;
        end else if (out_fire) begin
            state_nx = EMPTY;
        end
    end

    always_comb begin
        out_valid = state != EMPTY;
        out_data  = main_q;
        occupancy = state;
        in_ready  = (SKID != 0) ? ready_q : ((state == EMPTY) | out_ready);
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (SKID=1 main instance, SKID=0 side instance).
module tb_pipe_stage_reg;
    localparam int W = 112;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    logic         in_valid_b = 1'b0, out_ready_b = 1'b0, flush_b = 1'b0;
    logic [W-1:0] in_data_b = '0;
    logic         in_ready_b, out_valid_b;
    logic [W-1:0] out_data_b;
    logic [1:0]   occupancy_b;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0]  stall_cnt, stall_cnt_b;
`endif

    pipe_stage_reg #(.WIDTH(W), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush),
`ifdef PIPE_STAGE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_ready(out_ready_b), .flush(flush_b),
`ifdef PIPE_STAGE_STALL_CNT_EN
        .stall_cnt(stall_cnt_b),
`endif
        .occupancy(occupancy_b)
    );

    int errors = 0;
    int checks = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] hold_val = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: state after the previous edge is checked, then this edge's transfers are applied.
    always @(negedge clk) begin
        if (rst_n) begin
            check("occ", W'(occupancy), W'(sb.size()));
            check("in_ready", W'(in_ready), W'(sb.size() < 2));
            check("out_valid", W'(out_valid), W'(sb.size() != 0));
            check("out_data", out_data, sb.size() != 0 ? sb[0] : hold_val);
            if (out_valid && out_ready && sb.size() != 0)
                hold_val = sb.pop_front();
            if (flush) begin
                sb.delete();
                hold_val = '0;
            end else if (in_valid && in_ready) begin
                sb.push_back(in_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", W'(out_valid), '0);
        check("rst_data", out_data, '0);
        check("rst_occ", W'(occupancy), '0);
        check("rst_ready", W'(in_ready), W'(1));
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
            check("stream", out_data, W'(i));
            check("stream_ready", W'(in_ready), W'(1));
        end
        in_valid = 1'b0;
        repeat (2) tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(32'hA);
        tick();
        in_data = W'(32'hB);
        tick();
        in_valid = 1'b0;
        check("bp_occ", W'(occupancy), W'(2));
        check("bp_ready", W'(in_ready), '0);
        out_ready = 1'b1;
        check("bp_first", out_data, W'(32'hA));
        tick();
        check("bp_ready_back", W'(in_ready), W'(1));
        check("bp_second", out_data, W'(32'hB));
        tick();
        check("bp_drained", W'(out_valid), '0);
        out_ready = 1'b0;

        in_valid = 1'b1;
        in_data  = W'(32'hC);
        tick();
        flush   = 1'b1;
        in_data = W'(32'hD);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", W'(occupancy), '0);
        check("fl_data", out_data, '0);
        check("fl_valid", W'(out_valid), '0);
        out_ready = 1'b1;
        repeat (3) tick();

        repeat (300) begin
            in_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 24) == 0;
            in_data   = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(32'hE);
        tick();
        in_data = W'(32'hF);
        tick();
        in_valid = 1'b0;
        check("mr_occ2", W'(occupancy), W'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", W'(out_valid), '0);
        check("mr_data", out_data, '0);
        check("mr_occ", W'(occupancy), '0);
        check("mr_ready", W'(in_ready), W'(1));
        sb.delete();
        hold_val = '0;
        tick();
        rst_n = 1'b1;
        tick();

        in_valid_b  = 1'b1;
        in_data_b   = W'(32'h11);
        out_ready_b = 1'b0;
        tick();
        in_valid_b = 1'b0;
        #1;
        check("s0_ready_lo", W'(in_ready_b), '0);
        check("s0_occ", W'(occupancy_b), W'(1));
        check("s0_data", out_data_b, W'(32'h11));
        out_ready_b = 1'b1;
        #1;
        check("s0_ready_comb", W'(in_ready_b), W'(1));
        in_valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_b = W'(32'h20 + i);
            tick();
            check("s0_b2b", out_data_b, W'(32'h20 + i));
            check("s0_b2b_occ", W'(occupancy_b), W'(1));
        end
        in_valid_b = 1'b0;
        tick();
        check("s0_drain", W'(out_valid_b), '0);

`ifdef PIPE_STAGE_STALL_CNT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'(32'h5);
        tick();
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("stall_sat", W'(stall_cnt), W'(16'hFFFF));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_flush", W'(stall_cnt), W'(16'hFFFF));
        #2;
        rst_n = 1'b0;
        #1;
        check("stall_rst", W'(stall_cnt), '0);
        sb.delete();
        hold_val = '0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches of the LC-3b pipeline.
- One instance sits between each pair of stages and carries a packed stage payload (instruction, PC, control word, data) of WIDTH bits.
- Adds a valid/ready handshake, flush-to-bubble and an optional skid entry, so stalls are absorbed without a combinational ready path from downstream to upstream.

Parameters:
- WIDTH, 112, payload bits per entry; matches the widest stage bundle.
- SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- BUBBLE, '0, WIDTH-bit payload value driven on out_data after reset or flush; encodes a NOP with all load/write controls low.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a payload.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  this stage accepts in_data this cycle.
- out_valid  output  1  out_data holds a live payload.
- out_data  output  WIDTH  payload to the downstream stage.
- out_ready  input  1  downstream accepts out_data this cycle.
- flush  input  1  synchronous kill of all held entries (branch mispredict, trap).
- occupancy  output  2  number of live entries, 0..2.

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are evaluated on the same rising edge.
- Reset (rst_n low, asynchronous): out_valid=0, out_data=BUBBLE, occupancy=0, skid entry invalid, in_ready=1. Release is synchronous to the next clk edge.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N (1 cycle), provided the stage was empty or draining.
- SKID=1 state machine, encoded as occupancy:
  - EMPTY(0): in_fire -> FULL1, with main loaded from in_data.
  - FULL1(1):
    - in_fire & out_fire -> stay FULL1; main reloads from in_data.
    - in_fire & !out_fire -> FULL2; in_data goes to skid and main holds.
    - !in_fire & out_fire -> EMPTY.
  - FULL2(2): in_ready=0.
    - out_fire -> FULL1; main takes skid.
    - no out_fire -> hold.
  - in_ready is a flop: 1 in EMPTY and FULL1, 0 in FULL2. It has no combinational dependence on out_ready.
- SKID=0: a single main entry. in_ready = !out_valid | out_ready (combinational). occupancy never exceeds 1.
- out_data and out_valid are driven only from the main entry register.
- out_data holds its last value while out_valid=0 after a drain. It is forced to BUBBLE only by reset or flush.
- Flush:
  - At the edge where flush=1: both entries are invalidated, out_data is set to BUBBLE, occupancy is set to 0, and in_ready is set to 1.
  - Flush takes priority over a simultaneous in_fire; the incoming payload is discarded.
  - A simultaneous out_fire still counts as delivered downstream on that edge.
- Stable-hold rule: while out_valid=1 and out_ready=0, out_data must not change.
- Overflow is impossible by construction: in_ready=0 whenever both entries are live.
- Payload is opaque. No arithmetic is performed on it; widths pass through unchanged.

Optional Feature:
- Macro: PIPE_STAGE_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - Increments on every cycle with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst_n; not cleared by flush.
- When undefined: the port and counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-transfer with occupancy=2 -> out_valid=0, out_data=BUBBLE, occupancy=0 and in_ready=1 immediately, without a clock edge.
- Streaming, SKID=1: in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1 -> out_data sequence 0x1..0x8 one cycle later, in_ready constantly 1.
- Backpressure: load 0xA, 0xB with out_ready=0 -> occupancy=2 and in_ready=0. Then raise out_ready -> outputs 0xA then 0xB, in order with no loss; in_ready returns to 1 the cycle after the first out_fire.
- Flush collision: occupancy=1 holding 0xC; assert flush and in_valid=1 with 0xD on the same edge -> occupancy=0, out_data=BUBBLE, and 0xD never appears.
- SKID=0 build: out_ready=0 with occupancy=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally, and back-to-back transfers proceed.
- PIPE_STAGE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF. Flush -> stall_cnt still 16'hFFFF. rst_n low -> stall_cnt=0.
